// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU issue path: opcode ranges, instruction
// classes, execution-unit indices and scheduler state encodings.
package tpu_ctrl_pkg;

  localparam logic [5:0] OPC_NOP    = 6'h00;
  localparam logic [5:0] OPC_DMA_HI = 6'h0F;
  localparam logic [5:0] OPC_WT_HI  = 6'h17;
  localparam logic [5:0] OPC_SYS_HI = 6'h1F;
  localparam logic [5:0] OPC_VPU_HI = 6'h2F;
  localparam logic [5:0] OPC_HALT   = 6'h3E;
  localparam logic [5:0] OPC_SYNC   = 6'h3F;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_DMA,
    CLS_WT,
    CLS_SYS,
    CLS_VPU,
    CLS_SYNC,
    CLS_HALT,
    CLS_ILL
  } instr_class_e;

  // Bit positions in the {wt,dma,vpu,sys} unit vectors
  localparam int UNIT_SYS  = 0;
  localparam int UNIT_VPU  = 1;
  localparam int UNIT_DMA  = 2;
  localparam int UNIT_WT   = 3;
  localparam int NUM_UNITS = 4;

  // Encodings match the upper current_stage codes so they can be reported directly
  localparam logic [1:0] ST_RUN       = 2'b00;
  localparam logic [1:0] ST_SYNC_WAIT = 2'b10;
  localparam logic [1:0] ST_HALTED    = 2'b11;

endpackage

// File: rtl/tpu_opcode_decode.sv
// Combinational opcode classifier: maps a 6-bit opcode to its instruction
// class and, for unit operations, the one-hot target unit {wt,dma,vpu,sys}.
module tpu_opcode_decode
  import tpu_ctrl_pkg::*;
(
  input  logic [5:0]           opcode,
  output instr_class_e         cls,
  output logic [NUM_UNITS-1:0] unit_oh
);

  // Ranges are checked in ascending order so each branch only needs its upper bound
  always_comb begin
    cls     = CLS_ILL;
    unit_oh = '0;
    if (opcode == OPC_NOP) begin
      cls = CLS_NOP;
    end else if (opcode <= OPC_DMA_HI) begin
      cls               = CLS_DMA;
      unit_oh[UNIT_DMA] = 1'b1;
    end else if (opcode <= OPC_WT_HI) begin
      cls              = CLS_WT;
      unit_oh[UNIT_WT] = 1'b1;
    end else if (opcode <= OPC_SYS_HI) begin
      cls               = CLS_SYS;
      unit_oh[UNIT_SYS] = 1'b1;
    end else if (opcode <= OPC_VPU_HI) begin
      cls               = CLS_VPU;
      unit_oh[UNIT_VPU] = 1'b1;
    end else if (opcode == OPC_HALT) begin
      cls = CLS_HALT;
    end else if (opcode == OPC_SYNC) begin
      cls = CLS_SYNC;
    end
  end

endmodule

// File: rtl/tpu_issue_scheduler.sv
// Single-issue in-order scheduler feeding the SYS/VPU/DMA/WT units.
// Holds one instruction and issues it when its unit is free; handles SYNC
// barriers, HALT/resume and illegal opcodes.
// Optional feature macro: TPU_ISSUE_PERF_EN enables the retired-instruction
// and stall-cycle performance counters (tied to 0 otherwise).
module tpu_issue_scheduler
  import tpu_ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               sys_busy,
  input  logic               vpu_busy,
  input  logic               dma_busy,
  input  logic               wt_busy,
  input  logic               resume,
  output logic [3:0]         unit_issue,
  output logic [INSTR_W-1:0] issue_instr,
  output logic               pc_cnt,
  output logic               pipeline_stall,
  output logic [1:0]         current_stage,
  output logic               illegal_err,
  output logic [CNT_W-1:0]   instr_retired,
  output logic [CNT_W-1:0]   stall_cycles
);

  logic [1:0]           state;
  logic                 ir_valid;
  logic [INSTR_W-1:0]   ir;
  instr_class_e         ir_cls;
  logic [NUM_UNITS-1:0] ir_unit_oh;
  logic [NUM_UNITS-1:0] busy;
  logic [NUM_UNITS-1:0] eff_busy;
  logic                 is_unit_op;
  logic                 retire;
  logic                 issue_fire;
  logic                 accept;

  tpu_opcode_decode u_decode (
    .opcode  (ir[INSTR_W-1 -: 6]),
    .cls     (ir_cls),
    .unit_oh (ir_unit_oh)
  );

  assign busy = {wt_busy, dma_busy, vpu_busy, sys_busy};
  // A unit issued last edge has not raised busy yet; treat it as busy anyway
  assign eff_busy   = busy | unit_issue;
  assign is_unit_op = |ir_unit_oh;
  assign retire     = ir_valid && (state == ST_RUN) &&
                      (!is_unit_op || ((ir_unit_oh & eff_busy) == '0));
  assign issue_fire = retire && is_unit_op;

  assign in_ready       = (state == ST_RUN) && (!ir_valid || retire);
  assign accept         = in_valid && in_ready;
  assign pipeline_stall = ir_valid && !retire;
  assign current_stage  = (state == ST_RUN) ? {1'b0, ir_valid} : state;

  // Hold register payload; only meaningful while ir_valid is set
  always_ff @(posedge clk) begin
    if (accept) ir <= instr_data;
  end

  // Hold-register occupancy, issue pulses, retire pulse and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_valid    <= 1'b0;
      unit_issue  <= '0;
      issue_instr <= '0;
      pc_cnt      <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      if (accept)      ir_valid <= 1'b1;
      else if (retire) ir_valid <= 1'b0;
      unit_issue  <= issue_fire ? ir_unit_oh : '0;
      issue_instr <= issue_fire ? ir : '0;
      pc_cnt      <= retire;
      if (retire && (ir_cls == CLS_ILL)) illegal_err <= 1'b1;
    end
  end

  // Scheduler state: RUN, SYNC barrier wait, HALTED until resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (retire && (ir_cls == CLS_SYNC))      state <= ST_SYNC_WAIT;
          else if (retire && (ir_cls == CLS_HALT)) state <= ST_HALTED;
        end
        ST_SYNC_WAIT: begin
          if ((busy == '0) && (unit_issue == '0)) state <= ST_RUN;
        end
        ST_HALTED: begin
          if (resume) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef TPU_ISSUE_PERF_EN
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] stall_q;

  // Free-running perf counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire)         retired_q <= retired_q + CNT_W'(1);
      if (pipeline_stall) stall_q   <= stall_q + CNT_W'(1);
    end
  end

  assign instr_retired = retired_q;
  assign stall_cycles  = stall_q;
`else
  assign instr_retired = '0;
  assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_tpu_issue_scheduler.sv
// Self-checking bench for tpu_issue_scheduler: table-driven decode/issue
// vectors with a scoreboard of expected issues, plus hand-written sequences
// for stall, SYNC, HALT/resume, illegal opcode and mid-operation reset.
module tb_tpu_issue_scheduler;
  import tpu_ctrl_pkg::*;

  localparam int INSTR_W = 32;
  localparam int CNT_W   = 32;
`ifdef TPU_ISSUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_data;
  logic               sys_busy, vpu_busy, dma_busy, wt_busy;
  logic               resume;
  logic [3:0]         unit_issue;
  logic [INSTR_W-1:0] issue_instr;
  logic               pc_cnt;
  logic               pipeline_stall;
  logic [1:0]         current_stage;
  logic               illegal_err;
  logic [CNT_W-1:0]   instr_retired;
  logic [CNT_W-1:0]   stall_cycles;

  always #5 clk = ~clk;

  tpu_issue_scheduler #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instr_data     (instr_data),
    .sys_busy       (sys_busy),
    .vpu_busy       (vpu_busy),
    .dma_busy       (dma_busy),
    .wt_busy        (wt_busy),
    .resume         (resume),
    .unit_issue     (unit_issue),
    .issue_instr    (issue_instr),
    .pc_cnt         (pc_cnt),
    .pipeline_stall (pipeline_stall),
    .current_stage  (current_stage),
    .illegal_err    (illegal_err),
    .instr_retired  (instr_retired),
    .stall_cycles   (stall_cycles)
  );

  typedef struct {
    logic [3:0]         oh;
    logic [INSTR_W-1:0] ins;
  } sb_t;

  typedef struct {
    logic [5:0] op;
    logic [3:0] oh;
  } vec_t;

  sb_t  sb[$];
  int   issue_cyc[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   pc_total = 0;
  bit   ok;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // One clock: sample registered outputs 1ns after the edge, score any issue
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    pc_total += int'(pc_cnt);
    if (unit_issue != 4'b0000) begin
      issue_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("spurious_issue", 32'(unit_issue), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("issue_unit", 32'(unit_issue), 32'(e.oh));
        chk("issue_instr", issue_instr, e.ins);
      end
    end
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  // Present one instruction until accepted; queue its expected issue
  task automatic send(input logic [5:0] op, input logic [25:0] pl, input logic [3:0] exp_oh);
    logic acc;
    int   waited;
    sb_t  e;
    instr_data = {op, pl};
    in_valid   = 1'b1;
    acc        = 1'b0;
    waited     = 0;
    while (!acc && waited < 50) begin
      #1;
      acc = in_ready;
      tick();
      waited++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL accept_timeout: opcode 0x%0h not accepted within 50 cycles", op);
    end else if (exp_oh != 4'b0000) begin
      e.oh  = exp_oh;
      e.ins = {op, pl};
      sb.push_back(e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6'h01, 4'b0100};
    vecs[1] = '{6'h20, 4'b0010};
    vecs[2] = '{6'h10, 4'b1000};
    vecs[3] = '{6'h18, 4'b0001};
    vecs[4] = '{6'h0F, 4'b0100};
    vecs[5] = '{6'h2F, 4'b0010};
    vecs[6] = '{6'h17, 4'b1000};
    vecs[7] = '{6'h1F, 4'b0001};
    vecs[8] = '{6'h00, 4'b0000};

    rst_n = 1'b0; in_valid = 1'b0; instr_data = '0; resume = 1'b0;
    sys_busy = 1'b0; vpu_busy = 1'b0; dma_busy = 1'b0; wt_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_unit_issue", 32'(unit_issue), 32'd0);
    chk("rst_issue_instr", issue_instr, 32'd0);
    chk("rst_pc_cnt", 32'(pc_cnt), 32'd0);
    chk("rst_stage", 32'(current_stage), 32'd0);
    chk("rst_illegal", 32'(illegal_err), 32'd0);
    chk("rst_retired", instr_retired, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    #2 rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 20 NOPs streamed back-to-back
    pc_total = 0;
    ok = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instr_data = {OPC_NOP, 26'(i)};
      #1;
      if (!in_ready) ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    drain(2);
    chk("nop_ready_every_cycle", 32'(ok), 32'd1);
    chk("nop_pc_pulses", 32'(pc_total), 32'd20);
    chk("nop_retired", instr_retired, PERF ? 32'd20 : 32'd0);

    // SYS op held while sys_busy is high for 5 cycles
    sys_busy   = 1'b1;
    instr_data = {6'h18, 26'h0ABCDE};
    in_valid   = 1'b1;
    #1 chk("sys_accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    sb.push_back('{4'b0001, {6'h18, 26'h0ABCDE}});
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!pipeline_stall || unit_issue != 4'b0000) ok = 1'b0;
      tick();
    end
    chk("sys_stall_5_cycles", 32'(ok), 32'd1);
    sys_busy = 1'b0;
    #1 chk("sys_stall_release", 32'(pipeline_stall), 32'd0);
    tick();
    chk("sys_issued_after_busy_drop", 32'(sb.size()), 32'd0);
    chk("sys_stall_cycles", stall_cycles, PERF ? 32'd5 : 32'd0);
    chk("sys_retired", instr_retired, PERF ? 32'd21 : 32'd0);
    tick();

    // Decode-boundary table streamed to alternating free units
    issue_cyc.delete();
    for (int i = 0; i < 9; i++) send(vecs[i].op, 26'(i * 3 + 1), vecs[i].oh);
    drain(3);
    chk("table_issue_count", 32'(issue_cyc.size()), 32'd8);
    if (issue_cyc.size() == 8)
      for (int i = 0; i < 7; i++)
        chk("table_consecutive", 32'(issue_cyc[i+1] - issue_cyc[i]), 32'd1);

    // Two DMA ops back-to-back: second issues two cycles after the first
    issue_cyc.delete();
    send(6'h05, 26'h111, 4'b0100);
    send(6'h0F, 26'h222, 4'b0100);
    drain(4);
    chk("dma_pair_count", 32'(issue_cyc.size()), 32'd2);
    if (issue_cyc.size() == 2)
      chk("dma_pair_spacing", 32'(issue_cyc[1] - issue_cyc[0]), 32'd2);

    // SYNC barrier waits for vpu_busy; resume is ignored here
    vpu_busy = 1'b1;
    send(OPC_SYNC, 26'h0, 4'b0000);
    tick();
    in_valid   = 1'b1;
    instr_data = {OPC_NOP, 26'h5};
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      resume = (i == 2);
      #1;
      if (current_stage != 2'b10 || in_ready) ok = 1'b0;
      tick();
    end
    resume = 1'b0;
    chk("sync_wait_hold", 32'(ok), 32'd1);
    vpu_busy = 1'b0;
    #1 chk("sync_last_wait_cycle", 32'(in_ready), 32'd0);
    tick();
    #1;
    chk("sync_resumed_ready", 32'(in_ready), 32'd1);
    chk("sync_resumed_stage", 32'(current_stage), 32'd0);
    tick();
    in_valid = 1'b0;
    tick();

    // HALT for 10 cycles then resume
    send(OPC_HALT, 26'h0, 4'b0000);
    tick();
    in_valid   = 1'b1;
    instr_data = {OPC_NOP, 26'h7};
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (current_stage != 2'b11 || in_ready) ok = 1'b0;
      tick();
    end
    chk("halt_hold", 32'(ok), 32'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    chk("halt_resume_stage", 32'(current_stage), 32'd0);
    chk("halt_resume_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tick();

    // Illegal opcodes: sticky error, no issue, later ops still issue
    chk("illegal_before", 32'(illegal_err), 32'd0);
    send(6'h30, 26'h55, 4'b0000);
    tick();
    chk("illegal_set", 32'(illegal_err), 32'd1);
    send(6'h3D, 26'h0, 4'b0000);
    send(6'h21, 26'h99, 4'b0010);
    drain(3);
    chk("illegal_sticky", 32'(illegal_err), 32'd1);
    chk("illegal_then_vpu_issued", 32'(sb.size()), 32'd0);

    // Reset pulsed while a SYS op is held stalled
    sys_busy = 1'b1;
    send(6'h1A, 26'h3C3C, 4'b0000);
    tick();
    tick();
    #1;
    chk("pre_reset_stall", 32'(pipeline_stall), 32'd1);
    chk("pre_reset_stage", 32'(current_stage), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_unit_issue", 32'(unit_issue), 32'd0);
    chk("async_rst_issue_instr", issue_instr, 32'd0);
    chk("async_rst_pc_cnt", 32'(pc_cnt), 32'd0);
    chk("async_rst_stage", 32'(current_stage), 32'd0);
    chk("async_rst_stall", 32'(pipeline_stall), 32'd0);
    chk("async_rst_illegal", 32'(illegal_err), 32'd0);
    chk("async_rst_retired", instr_retired, 32'd0);
    chk("async_rst_stall_cycles", stall_cycles, 32'd0);
    sys_busy = 1'b0;
    #1 rst_n = 1'b1;
    #1 chk("post_reset_ready", 32'(in_ready), 32'd1);
    issue_cyc.delete();
    drain(5);
    chk("post_reset_no_issue", 32'(issue_cyc.size()), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
